// File: rtl/multi_digit_counter.sv
// Parametrised multi-digit up/down modulus counter with parallel load,
// wrap/saturate terminal handling, combinational terminal count and rollover pulse.
module multi_digit_counter #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned FINAL_VALUE = 9,
  parameter int unsigned WIDTH       = $clog2(FINAL_VALUE + 1),
  parameter int unsigned SATURATE    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      up,
  input  logic                      load,
  input  logic [DIGITS*WIDTH-1:0]   load_value,
  output logic [DIGITS*WIDTH-1:0]   count,
  output logic                      tc,
  output logic                      rollover
);

  localparam logic [WIDTH-1:0] FV = WIDTH'(FINAL_VALUE);

  logic [WIDTH-1:0] dig_q [DIGITS];
  logic [WIDTH-1:0] dig_d [DIGITS];
  logic             rollover_q;
  logic             rollover_d;
  logic             all_max;
  logic             all_zero;
  logic             at_term;
  logic             chain;
  logic [WIDTH-1:0] field;

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      all_max  = all_max  & (dig_q[i] == FV);
      all_zero = all_zero & (dig_q[i] == '0);
    end
    at_term = up ? all_max : all_zero;
  end

  // Carry/borrow ripples through 'chain': digit i steps only if every lower
  // digit sits at the direction's boundary value.
  always_comb begin
    dig_d      = dig_q;
    rollover_d = 1'b0;
    chain      = 1'b1;
    field      = '0;
    if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        field    = load_value[i*WIDTH +: WIDTH];
        dig_d[i] = (field > FV) ? FV : field;
      end
    end else if (enable) begin
      rollover_d = at_term;
      if (!(at_term && (SATURATE != 0))) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (chain) begin
            if (up) dig_d[i] = (dig_q[i] == FV) ? '0 : dig_q[i] + WIDTH'(1);
            else    dig_d[i] = (dig_q[i] == '0) ? FV : dig_q[i] - WIDTH'(1);
          end
          chain = chain & (up ? (dig_q[i] == FV) : (dig_q[i] == '0));
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DIGITS; i++) dig_q[i] <= '0;
      rollover_q <= 1'b0;
    end else begin
      dig_q      <= dig_d;
      rollover_q <= rollover_d;
    end
  end

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < DIGITS; i++) count[i*WIDTH +: WIDTH] = dig_q[i];
  end

  assign tc       = enable && at_term;
  assign rollover = rollover_q;

endmodule

// File: tb/tb_multi_digit_counter.sv
// Self-checking bench: wrap and saturate instances (2 BCD digits) driven in
// lockstep and compared against an integer-valued reference model.
module tb_multi_digit_counter;

  localparam int N = 100;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       up;
  logic       load;
  logic [7:0] load_value;
  logic [7:0] count_w, count_s;
  logic       tc_w, tc_s, ro_w, ro_s;

  int n_assert = 0;
  int n_fail   = 0;
  int mw = 0, ms = 0;
  bit rw = 1'b0, rs = 1'b0;

  always #5 clk = ~clk;

  multi_digit_counter #(.DIGITS(2), .FINAL_VALUE(9), .SATURATE(0)) u_wrap (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_w), .tc(tc_w), .rollover(ro_w));

  multi_digit_counter #(.DIGITS(2), .FINAL_VALUE(9), .SATURATE(1)) u_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .count(count_s), .tc(tc_s), .rollover(ro_s));

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int lo, hi;
    lo = int'(lv[3:0]);
    hi = int'(lv[7:4]);
    if (lo > 9) lo = 9;
    if (hi > 9) hi = 9;
    return hi * 10 + lo;
  endfunction

  function automatic bit is_term(input int v, input bit dir_up);
    return dir_up ? (v == N - 1) : (v == 0);
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_tc();
    #1;
    chk("tc_wrap", {7'd0, tc_w}, {7'd0, enable && is_term(mw, up)});
    chk("tc_sat",  {7'd0, tc_s}, {7'd0, enable && is_term(ms, up)});
  endtask

  task automatic model_step(inout int m, inout bit r, input bit sat);
    if (!reset_n) begin
      m = 0; r = 1'b0;
    end else if (load) begin
      m = clamp_val(load_value); r = 1'b0;
    end else if (enable) begin
      if (is_term(m, up)) begin
        r = 1'b1;
        if (!sat) m = up ? 0 : N - 1;
      end else begin
        r = 1'b0;
        m = up ? m + 1 : m - 1;
      end
    end else begin
      r = 1'b0;
    end
  endtask

  task automatic tick();
    model_step(mw, rw, 1'b0);
    model_step(ms, rs, 1'b1);
    @(posedge clk);
    @(negedge clk);
    chk("count_wrap", count_w, to_bcd(mw));
    chk("count_sat",  count_s, to_bcd(ms));
    chk("ro_wrap", {7'd0, ro_w}, {7'd0, rw});
    chk("ro_sat",  {7'd0, ro_s}, {7'd0, rs});
    chk("tc_wrap", {7'd0, tc_w}, {7'd0, enable && is_term(mw, up)});
    chk("tc_sat",  {7'd0, tc_s}, {7'd0, enable && is_term(ms, up)});
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; up = 1'b1; load = 1'b0; load_value = 8'h00;
    @(negedge clk);

    // Reset held with enable, then ten up-counts
    tick(); tick();
    chk("reset_count", count_w, 8'h00);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("count_after_10", count_w, 8'h10);

    // Up wrap at 99
    do_load(8'h99);
    up = 1'b1; enable = 1'b1;
    check_tc();
    chk("tc_at_99", {7'd0, tc_w}, 8'h01);
    tick();
    chk("wrap_to_00", count_w, 8'h00);
    chk("wrap_ro", {7'd0, ro_w}, 8'h01);
    tick();
    chk("after_wrap", count_w, 8'h01);

    // Down wrap at 00, borrow across digits
    enable = 1'b0;
    do_load(8'h00);
    up = 1'b0; enable = 1'b1;
    check_tc();
    chk("tc_at_00", {7'd0, tc_w}, 8'h01);
    tick();
    chk("down_wrap", count_w, 8'h99);
    tick(); tick();
    chk("down_97", count_w, 8'h97);
    do_load(8'h90);
    tick();
    chk("borrow", count_w, 8'h89);

    // Saturation at 99, then turnaround
    do_load(8'h99);
    up = 1'b1; enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sat_hold", count_s, 8'h99);
      chk("sat_ro", {7'd0, ro_s}, 8'h01);
    end
    up = 1'b0;
    tick();
    chk("sat_down", count_s, 8'h98);
    chk("sat_down_ro", {7'd0, ro_s}, 8'h00);

    // Load clamping beats enable
    enable = 1'b1;
    do_load(8'hF3);
    chk("clamp_F3", count_w, 8'h93);
    do_load(8'h5A);
    chk("clamp_5A", count_w, 8'h59);

    // Reset beats load and enable
    do_load(8'h47);
    reset_n = 1'b0; load = 1'b1; enable = 1'b1; load_value = 8'h55;
    tick();
    chk("mid_reset", count_w, 8'h00);
    reset_n = 1'b1; load = 1'b0; up = 1'b1;
    tick();
    chk("post_reset", count_w, 8'h01);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset_n    = ($urandom_range(0, 49) != 0);
      load       = ($urandom_range(0, 15) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up         = ($urandom_range(0, 4) != 0) ? up : ~up;
      load_value = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        load = 1'b1;
        load_value = ($urandom_range(0, 1) != 0) ? 8'h99 : 8'h00;
      end
      check_tc();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
